// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential fp32 divider.
// Optional feature macro used by the design: FPU_DIV_RMODE_EN (selectable rounding mode).
package fp_div_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIVIDE,
    NORM,
    ROUND,
    DONE
  } div_state_t;

  localparam int          BIAS       = 127;
  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  // Rounding mode encodings; unlisted codes fall back to RNE.
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

endpackage

// File: rtl/fp_div_round.sv
// Combinational rounder: adds one ulp to a 24-bit mantissa (hidden bit included) when the
// rounding mode, guard/round/sticky bits and sign call for it. Returns the 23-bit fraction
// and the carry out of the hidden bit.
module fp_div_round
  import fp_div_pkg::*;
(
  input  logic [23:0] i_mant,
  input  logic        i_guard,
  input  logic        i_round,
  input  logic        i_sticky,
  input  logic        i_sign,
  input  logic [2:0]  i_mode,
  output logic [22:0] o_mant,
  output logic        o_carry
);

  logic w_inexact;
  logic w_inc;

  // Decide the increment, then apply it; carry only when every mantissa bit was set.
  always_comb begin
    w_inexact = i_guard | i_round | i_sticky;
    w_inc     = 1'b0;
    case (i_mode)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = i_sign & w_inexact;
      RM_RUP:  w_inc = ~i_sign & w_inexact;
      RM_RMM:  w_inc = i_guard;
      default: w_inc = i_guard & (i_round | i_sticky | i_mant[0]);
    endcase
    o_mant  = i_mant[22:0] + 23'(w_inc);
    o_carry = (&i_mant) & w_inc;
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring division, one quotient bit per
// cycle, valid/ready on operand and result sides. Denormal inputs flush to zero and no
// denormal results are produced.
// Optional feature macro: FPU_DIV_RMODE_EN adds the frm port (latched at acceptance);
// without it rounding is always round-to-nearest-even.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned QUOT_BITS = 27  // 24 mantissa + guard + round + spare; minimum 27
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef FPU_DIV_RMODE_EN
  input  logic [2:0]  frm,
`endif
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        div_by_zero,
  output logic        busy
);

  localparam logic [4:0] CNT_LAST = 5'(QUOT_BITS - 1);

  div_state_t            r_state, w_state_next;
  fp32_t                 r_a, r_b;
  logic                  r_sign, r_special, r_sticky;
  logic signed [9:0]     r_exp;
  logic [24:0]           r_rem;
  logic [23:0]           r_div;
  logic [QUOT_BITS-1:0]  r_q;
  logic [4:0]            r_cnt;
  logic [31:0]           r_result;
  logic                  r_ovf, r_unf, r_dbz;

  logic                  w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic                  w_sign, w_special, w_spec_dbz;
  logic [31:0]           w_spec_result;
  logic                  w_rem_ge;
  logic [24:0]           w_rem_sub;
  logic [22:0]           w_rnd_frac;
  logic                  w_rnd_carry;
  logic signed [9:0]     w_exp_fin;
  logic                  w_ovf_max;
  logic [2:0]            w_mode;

`ifdef FPU_DIV_RMODE_EN
  logic [2:0] r_frm;
  assign w_mode = r_frm;
`else
  assign w_mode = RM_RNE;
`endif

  assign start_ready  = (r_state == IDLE);
  assign result_valid = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign result       = r_result;
  assign ovf          = r_ovf;
  assign unf          = r_unf;
  assign div_by_zero  = r_dbz;

  // Classify latched operands and pick the fixed result for special cases.
  always_comb begin
    w_sign        = r_a.sign ^ r_b.sign;
    w_a_zero      = (r_a.exp == 8'd0);
    w_b_zero      = (r_b.exp == 8'd0);
    w_a_inf       = (r_a.exp == 8'hFF) && (r_a.mant == 23'd0);
    w_b_inf       = (r_b.exp == 8'hFF) && (r_b.mant == 23'd0);
    w_a_nan       = (r_a.exp == 8'hFF) && (r_a.mant != 23'd0);
    w_b_nan       = (r_b.exp == 8'hFF) && (r_b.mant != 23'd0);
    w_special     = 1'b1;
    w_spec_dbz    = 1'b0;
    w_spec_result = CANON_NAN;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_result = CANON_NAN;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_result = {w_sign, POS_INF[30:0]};
      w_spec_dbz    = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_result = {w_sign, 31'd0};
    end else if (w_a_inf) begin
      w_spec_result = {w_sign, POS_INF[30:0]};
    end else begin
      w_special = 1'b0;
    end
  end

  // One restoring step: remainder stays below twice the divisor, so 25 bits suffice.
  always_comb begin
    w_rem_ge  = (r_rem >= {1'b0, r_div});
    w_rem_sub = w_rem_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  end

  fp_div_round u_round (
    .i_mant   (r_q[QUOT_BITS-1 -: 24]),
    .i_guard  (r_q[QUOT_BITS-25]),
    .i_round  (r_q[QUOT_BITS-26]),
    .i_sticky (r_sticky | (|r_q[QUOT_BITS-27:0])),
    .i_sign   (r_sign),
    .i_mode   (w_mode),
    .o_mant   (w_rnd_frac),
    .o_carry  (w_rnd_carry)
  );

  // Final exponent after rounding carry, and whether overflow saturates to max finite.
  always_comb begin
    w_exp_fin = r_exp + $signed({9'd0, w_rnd_carry});
`ifdef FPU_DIV_RMODE_EN
    w_ovf_max = (w_mode == RM_RTZ) || ((w_mode == RM_RDN) && !r_sign) ||
                ((w_mode == RM_RUP) && r_sign);
`else
    w_ovf_max = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; specials borrow the ROUND slot so they land two cycles after acceptance.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start_valid) w_state_next = CHECK;
      CHECK:   w_state_next = w_special ? ROUND : DIVIDE;
      DIVIDE:  if (r_cnt == CNT_LAST) w_state_next = NORM;
      NORM:    w_state_next = ROUND;
      ROUND:   w_state_next = DONE;
      DONE:    if (result_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_sticky  <= 1'b0;
      r_exp     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_dbz     <= 1'b0;
`ifdef FPU_DIV_RMODE_EN
      r_frm     <= RM_RNE;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a <= op_a;
            r_b <= op_b;
`ifdef FPU_DIV_RMODE_EN
            r_frm <= frm;
`endif
          end
        end
        CHECK: begin
          r_sign    <= w_sign;
          r_special <= w_special;
          r_exp     <= $signed({2'b00, r_a.exp}) - $signed({2'b00, r_b.exp}) +
                       $signed(10'(BIAS));
          r_rem     <= {2'b01, r_a.mant};
          r_div     <= {1'b1, r_b.mant};
          r_q       <= '0;
          r_cnt     <= '0;
          if (w_special) begin
            r_result <= w_spec_result;
            r_dbz    <= w_spec_dbz;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end
        end
        DIVIDE: begin
          r_q   <= {r_q[QUOT_BITS-2:0], w_rem_ge};
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          if (!r_q[QUOT_BITS-1]) begin
            r_q   <= r_q << 1;
            r_exp <= r_exp - 10'sd1;
          end
          r_sticky <= |r_rem;
        end
        ROUND: begin
          if (!r_special) begin
            r_dbz <= 1'b0;
            if (w_exp_fin >= 10'sd255) begin
              r_ovf    <= 1'b1;
              r_unf    <= 1'b0;
              r_result <= w_ovf_max ? {r_sign, MAX_FINITE[30:0]} : {r_sign, POS_INF[30:0]};
            end else if (w_exp_fin <= 10'sd0) begin
              r_ovf    <= 1'b0;
              r_unf    <= 1'b1;
              r_result <= {r_sign, 31'd0};
            end else begin
              r_ovf    <= 1'b0;
              r_unf    <= 1'b0;
              r_result <= {r_sign, w_exp_fin[7:0], w_rnd_frac};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq: normal quotients, specials, range limits,
// result back-pressure and asynchronous reset during the divide loop.
module tb_fp_div_seq;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a, op_b;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        ovf, unf, div_by_zero, busy;
`ifdef FPU_DIV_RMODE_EN
  logic [2:0]  frm = 3'b000;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_seq dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
`ifdef FPU_DIV_RMODE_EN
    .frm          (frm),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .ovf          (ovf),
    .unf          (unf),
    .div_by_zero  (div_by_zero),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge; the next rising edge is the handshake.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    op_a        = a;
    op_b        = b;
    start_valid = 1'b1;
    @(posedge CLK);
    #1 start_valid = 1'b0;
  endtask

  // Rising edges from the handshake until result_valid is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge CLK);
      #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge CLK);
    result_ready = 1'b1;
    @(posedge CLK);
    #1 result_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags,
                       input int exp_lat);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check_eq({tag, " result"}, result, exp_res);
    check_eq({tag, " flags"}, {29'd0, ovf, unf, div_by_zero}, {29'd0, exp_flags});
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    release_result();
    check_eq({tag, " back to idle"}, {30'd0, start_ready, busy}, 32'd2);
  endtask

  initial begin
    int          lat;
    logic [31:0] held;

    nRST         = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    op_a         = '0;
    op_b         = '0;

    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset result", result, 32'h0);
    check_eq("reset status", {26'd0, start_ready, busy, result_valid, ovf, unf, div_by_zero},
             32'h20);
    @(negedge CLK) nRST = 1'b1;

    // Normal path
    do_op("6/2",     32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 30);
    do_op("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 30);
    do_op("2/-4",    32'h40000000, 32'hC0800000, 32'hBF000000, 3'b000, 30);
`ifdef FPU_DIV_RMODE_EN
    frm = 3'b001;
    do_op("1/3 rtz", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 30);
    do_op("ovf rtz", 32'h7F000000, 32'h00800000, 32'h7F7FFFFF, 3'b100, 30);
    frm = 3'b000;
`endif

    // Specials
    do_op("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2);
    do_op("0/0",     32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 2);
    do_op("-inf/2",  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 2);
    do_op("nan/1",   32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b000, 2);
    do_op("1/inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 3'b000, 2);
    do_op("denorm",  32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 2);

    // Range limits
    do_op("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100, 30);
    do_op("unf",     32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 30);

    // Back-pressure: hold DONE for 5 cycles
    start_op(32'h40C00000, 32'h40000000);
    wait_done(lat);
    check_eq("bp latency", 32'(lat), 32'd30);
    held = result;
    check_eq("bp result", held, 32'h40400000);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check_eq("bp result stable", result, 32'h40400000);
      check_eq("bp status", {27'd0, start_ready, result_valid, ovf, unf, div_by_zero},
               32'h08);
    end
    release_result();
    check_eq("bp released", {30'd0, start_ready, result_valid}, 32'd2);

    // Asynchronous reset during the divide loop
    start_op(32'h40C00000, 32'h40000000);
    repeat (11) @(posedge CLK);
    #1;
    check_eq("mid-divide busy", {31'd0, busy}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    check_eq("reset mid-divide status", {29'd0, result_valid, busy, start_ready}, 32'd1);
    check_eq("reset mid-divide result", result, 32'h0);
    @(negedge CLK) nRST = 1'b1;
    do_op("6/2 after reset", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
